// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register with load extraction, destination/result select,
// a registered register-file write port and a retired-instruction counter.
module writeback_stage #(
   parameter int         COUNT_WIDTH = 32,
   parameter logic [4:0] LINK_REG    = 5'd31
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   flush,
   input  logic                   in_reg_write,
   input  logic                   in_mem_to_reg,
   input  logic                   in_link,
   input  logic                   in_reg_dst,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [31:0]            in_alu_result,
   input  logic [31:0]            in_mem_data,
   input  logic [31:0]            in_pc_plus4,
   input  logic [2:0]             in_load_type,
   output logic [4:0]             write_reg,
   output logic [31:0]            write_data,
   output logic                   regWrite,
   output logic                   wb_valid,
   output logic [COUNT_WIDTH-1:0] retire_count
);
   logic                   w_cap;
   logic [4:0]             w_dst;
   logic [1:0]             w_off;
   logic [15:0]            w_half;
   logic [7:0]             w_byte;
   logic [31:0]            w_load;
   logic [31:0]            w_data;
   logic [4:0]             r_reg;
   logic [31:0]            r_data;
   logic                   r_we;
   logic                   r_valid;
   logic [COUNT_WIDTH-1:0] r_cnt;

   always_comb begin
      w_cap  = in_valid & ~flush;
      w_dst  = in_link ? LINK_REG : in_reg_dst ? in_rd : in_rt;
      w_off  = in_alu_result[1:0];
      // big-endian lanes: offset 0 selects the most significant byte/half
      w_half = w_off[1] ? in_mem_data[15:0] : in_mem_data[31:16];
      w_byte = w_off == 2'd0 ? in_mem_data[31:24] :
               w_off == 2'd1 ? in_mem_data[23:16] :
               w_off == 2'd2 ? in_mem_data[15:8]  : in_mem_data[7:0];
      w_load = in_load_type == 3'd1 ? {{16{w_half[15]}}, w_half} :
               in_load_type == 3'd2 ? {16'b0, w_half} :
               in_load_type == 3'd3 ? {{24{w_byte[7]}}, w_byte} :
               in_load_type == 3'd4 ? {24'b0, w_byte} : in_mem_data;
      w_data = in_link ? in_pc_plus4 : in_mem_to_reg ? w_load : in_alu_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg   <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_valid <= w_cap;
         r_reg   <= w_cap ? w_dst : 5'd0;
         r_data  <= w_cap ? w_data : 32'd0;
         r_we    <= w_cap & in_reg_write & (w_dst != 5'd0);
         if (w_cap)
            r_cnt <= r_cnt + COUNT_WIDTH'(1);
      end
   end

   assign write_reg    = r_reg;
   assign write_data   = r_data;
   assign regWrite     = r_we;
   assign wb_valid     = r_valid;
   assign retire_count = r_cnt;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed checks of capture, load extraction, destination select,
// flush priority, counter wrap (4-bit counter) and asynchronous reset.
module tb_writeback_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0, flush = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
   logic        in_link = 1'b0, in_reg_dst = 1'b0;
   logic [4:0]  in_rt = '0, in_rd = '0;
   logic [31:0] in_alu_result = '0, in_mem_data = '0, in_pc_plus4 = '0;
   logic [2:0]  in_load_type = '0;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        regWrite, wb_valid;
   logic [3:0]  retire_count;
   int          n_checks = 0;
   int          n_fail = 0;

   writeback_stage #(.COUNT_WIDTH(4), .LINK_REG(5'd31)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
      .in_reg_dst(in_reg_dst), .in_rt(in_rt), .in_rd(in_rd), .in_alu_result(in_alu_result),
      .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4), .in_load_type(in_load_type),
      .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
      .wb_valid(wb_valid), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic fl, input logic rw, input logic m2r,
                       input logic lk, input logic rdst, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] lt);
      in_valid = v; flush = fl; in_reg_write = rw; in_mem_to_reg = m2r; in_link = lk;
      in_reg_dst = rdst; in_rt = rt; in_rd = rd; in_alu_result = alu; in_load_type = lt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 3'd0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_write_reg", 32'(write_reg), 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check("rst_regWrite", 32'(regWrite), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_count", 32'(retire_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      idle();
      check("idle_regWrite", 32'(regWrite), 32'd0);
      check("idle_count", 32'(retire_count), 32'd0);

      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd8, 32'h0000_1234, 3'd0);
      check("rtype_reg", 32'(write_reg), 32'd8);
      check("rtype_data", write_data, 32'h0000_1234);
      check("rtype_we", 32'(regWrite), 32'd1);
      check("rtype_count", 32'(retire_count), 32'd1);
      idle();
      check("rtype_pulse_end", 32'(regWrite), 32'd0);

      in_mem_data = 32'h80F1_7F22;
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0100, 3'd3);
      check("lb_off0", write_data, 32'hFFFF_FF80);
      check("lb_reg", 32'(write_reg), 32'd9);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0101, 3'd4);
      check("lbu_off1", write_data, 32'h0000_00F1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0102, 3'd3);
      check("lb_off2", write_data, 32'h0000_007F);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0102, 3'd1);
      check("lh_off2", write_data, 32'h0000_7F22);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0100, 3'd2);
      check("lhu_off0", write_data, 32'h0000_80F1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd4, 32'h0000_0103, 3'd0);
      check("lw_off3", write_data, 32'h80F1_7F22);
      check("lw_we", 32'(regWrite), 32'd1);
      check("loads_count", 32'(retire_count), 32'd7);

      in_pc_plus4 = 32'h0040_0010;
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd8, 32'h0000_5555, 3'd0);
      check("link_reg", 32'(write_reg), 32'd31);
      check("link_data", write_data, 32'h0040_0010);
      check("link_we", 32'(regWrite), 32'd1);

      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 32'h0000_0042, 3'd0);
      check("r0_we", 32'(regWrite), 32'd0);
      check("r0_valid", 32'(wb_valid), 32'd1);
      check("r0_count", 32'(retire_count), 32'd9);

      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd7, 32'h0000_0077, 3'd0);
      check("flush_we", 32'(regWrite), 32'd0);
      check("flush_valid", 32'(wb_valid), 32'd0);
      check("flush_count", 32'(retire_count), 32'd9);
      check("flush_reg", 32'(write_reg), 32'd0);
      check("flush_data", write_data, 32'd0);

      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'(i), 32'(i * 16), 3'd0);
         check("b2b_we", 32'(regWrite), 32'd1);
         check("b2b_reg", 32'(write_reg), 32'(i));
         check("b2b_data", write_data, 32'(i * 16));
      end
      check("b2b_count", 32'(retire_count), 32'd12);
      idle();
      check("b2b_end", 32'(regWrite), 32'd0);

      #2 rst_n = 1'b0;
      #1;
      check("rst2_count", 32'(retire_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++)
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 32'(i), 3'd0);
      check("pre_wrap_count", 32'(retire_count), 32'd15);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 32'h0000_00AA, 3'd0);
      check("wrap_count", 32'(retire_count), 32'd0);
      check("wrap_we", 32'(regWrite), 32'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h0000_00BB, 3'd0);
      check("burst_we", 32'(regWrite), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", 32'(regWrite), 32'd0);
      check("midrst_reg", 32'(write_reg), 32'd0);
      check("midrst_data", write_data, 32'd0);
      check("midrst_valid", 32'(wb_valid), 32'd0);
      check("midrst_count", 32'(retire_count), 32'd0);
      @(posedge clk);
      #1;
      check("held_rst_we", 32'(regWrite), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
